// File: rtl/cmd_scheduler.sv
// rtl/cmd_scheduler.sv - arbitrates gravity/down/rotate/left/right requests into one datapath command at a time
module cmd_scheduler #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned STEP       = 3000000,
  parameter int unsigned MIN_PERIOD = 5000000,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       rotate,
  input  logic       left,
  input  logic       right,
  input  logic       down,
  input  logic [3:0] level,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_done,
  output logic       dropped,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t      state, state_nxt;
  logic [4:0]  pend, pend_nxt, set_vec, clr_vec, eff;
  logic [31:0] grav_cnt, grav_nxt, wait_cnt, wait_nxt;
  logic [31:0] prod, period;
  logic [2:0]  cmd_nxt, sel;
  logic        cmd_valid_nxt, timeout_nxt, tick, soft_done;

  // Subtraction is guarded so a level*STEP beyond TICK_DIV saturates instead of wrapping.
  always_comb begin
    prod = 32'(level) * STEP;
    if (prod >= TICK_DIV)
      period = MIN_PERIOD;
    else if (TICK_DIV - prod < MIN_PERIOD)
      period = MIN_PERIOD;
    else
      period = TICK_DIV - prod;
  end

  assign tick      = enable && (grav_cnt == period - 32'd1);
  assign soft_done = (state == BUSY) && cmd_done && (cmd == 3'd2);

  always_comb begin
    grav_nxt = grav_cnt + 32'd1;
    if (!enable || soft_done || tick || grav_cnt >= period)
      grav_nxt = '0;
  end

  // Bit order doubles as priority: gravity, down, rotate, left, right.
  assign set_vec = enable ? {right, left, rotate, down, tick} : 5'b0;
  assign eff     = pend | set_vec;

  always_comb begin
    state_nxt     = state;
    cmd_nxt       = cmd;
    cmd_valid_nxt = cmd_valid;
    wait_nxt      = wait_cnt;
    timeout_nxt   = timeout_err;
    clr_vec       = '0;
    sel           = '0;
    for (int i = 4; i >= 0; i--)
      if (eff[i]) sel = 3'(i);
    case (state)
      IDLE: begin
        wait_nxt = '0;
        if (enable && |eff) begin
          cmd_nxt       = sel + 3'd1;
          cmd_valid_nxt = 1'b1;
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (cmd_done || wait_cnt == TIMEOUT - 32'd1) begin
          if (!cmd_done) timeout_nxt = 1'b1;
          clr_vec       = 5'b00001 << (cmd - 3'd1);
          cmd_nxt       = '0;
          cmd_valid_nxt = 1'b0;
          state_nxt     = GAP;
        end else begin
          wait_nxt = wait_cnt + 32'd1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A set arriving together with a clear keeps the bit pending.
    pend_nxt = enable ? ((pend & ~clr_vec) | set_vec) : 5'b0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      pend        <= '0;
      grav_cnt    <= '0;
      wait_cnt    <= '0;
      cmd_valid   <= 1'b0;
      cmd         <= '0;
      dropped     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend        <= pend_nxt;
      grav_cnt    <= grav_nxt;
      wait_cnt    <= wait_nxt;
      cmd_valid   <= cmd_valid_nxt;
      cmd         <= cmd_nxt;
      dropped     <= |(set_vec & pend);
      timeout_err <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_cmd_scheduler.sv
// tb/tb_cmd_scheduler.sv - directed self-checking bench for cmd_scheduler
module tb_cmd_scheduler;

  logic       clk = 1'b0;
  logic       clr, enable, rotate, left, right, down, cmd_done;
  logic [3:0] level;
  logic       cmd_valid, dropped, timeout_err;
  logic [2:0] cmd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int r0, t1, cnt;

  always #5 clk = ~clk;

  cmd_scheduler #(.TICK_DIV(20), .STEP(4), .MIN_PERIOD(8), .TIMEOUT(16)) dut (
    .clk(clk), .clr(clr), .enable(enable), .rotate(rotate), .left(left),
    .right(right), .down(down), .level(level), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_done(cmd_done), .dropped(dropped), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task ack();
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
  endtask

  task restart();
    enable = 1'b0;
    step();
    enable = 1'b1;
    r0 = cyc;
  endtask

  task automatic wait_issue(input int max);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic count_valid(input int ncyc, output int c);
    c = 0;
    repeat (ncyc) begin
      step();
      if (cmd_valid === 1'b1) c++;
    end
  endtask

  initial begin
    clr = 1'b1; enable = 1'b0; rotate = 1'b0; left = 1'b0; right = 1'b0;
    down = 1'b0; cmd_done = 1'b0; level = 4'd0;
    #2;
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_cmd", cmd, 3'd0);
    check("rst_dropped", dropped, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    @(posedge clk); #1;
    clr = 1'b0;

    // latency and hold
    restart();
    rotate = 1'b1; step(); rotate = 1'b0;
    check("lat_valid", cmd_valid, 1'b1);
    check("lat_cmd", cmd, 3'd3);
    step();
    check("hold_valid", cmd_valid, 1'b1);
    ack();
    check("gap_valid", cmd_valid, 1'b0);
    check("gap_cmd", cmd, 3'd0);

    // drop
    restart();
    rotate = 1'b1; step(); rotate = 1'b0; left = 1'b1;
    check("drop_rot", cmd, 3'd3);
    step();
    step(); left = 1'b0;
    check("drop_pulse", dropped, 1'b1);
    step();
    check("drop_once", dropped, 1'b0);
    ack();
    check("drop_gap", cmd_valid, 1'b0);
    wait_issue(10);
    check("drop_left_cmd", cmd, 3'd4);
    check("drop_left_time", cyc - r0, 7);
    ack();
    count_valid(6, cnt);
    check("drop_single", cnt, 0);

    // priority
    restart();
    repeat (19) step();
    rotate = 1'b1; left = 1'b1;
    step();
    rotate = 1'b0; left = 1'b0;
    check("prio_1", cmd, 3'd1);
    check("prio_nodrop", dropped, 1'b0);
    ack();
    check("prio_gap1", cmd_valid, 1'b0);
    step(); step();
    check("prio_3", cmd, 3'd3);
    ack();
    step(); step();
    check("prio_4", cmd, 3'd4);
    ack();

    // gravity period level 0
    restart();
    wait_issue(30);
    check("grav_first", cyc - r0, 20);
    check("grav_cmd", cmd, 3'd1);
    t1 = cyc;
    step(); step(); ack();
    wait_issue(30);
    check("grav_period", cyc - t1, 20);

    // saturated period at level 5, unsaturated at level 2
    ack();
    level = 4'd5;
    restart();
    wait_issue(20);
    check("lvl5_first", cyc - r0, 8);
    t1 = cyc; ack();
    wait_issue(20);
    check("lvl5_period", cyc - t1, 8);
    ack();
    level = 4'd2;
    restart();
    wait_issue(20);
    check("lvl2_first", cyc - r0, 12);
    t1 = cyc; ack();
    wait_issue(20);
    check("lvl2_period", cyc - t1, 12);
    ack();
    level = 4'd0;

    // soft drop at counter 15
    restart();
    repeat (13) step();
    down = 1'b1; step(); down = 1'b0;
    check("soft_cmd", cmd, 3'd2);
    step();
    ack();
    t1 = cyc;
    wait_issue(40);
    check("soft_delay", cyc - t1, 20);
    check("soft_grav", cmd, 3'd1);
    ack();

    // enable low: in-flight completes, nothing new
    restart();
    rotate = 1'b1; step(); rotate = 1'b0;
    enable = 1'b0; left = 1'b1; step(); left = 1'b0;
    check("en_inflight", cmd, 3'd3);
    ack();
    count_valid(25, cnt);
    check("en_idle", cnt, 0);

    // timeout
    restart();
    right = 1'b1; step(); right = 1'b0; down = 1'b1;
    check("to_cmd", cmd, 3'd5);
    step(); down = 1'b0;
    repeat (14) step();
    check("to_still_busy", cmd_valid, 1'b1);
    check("to_not_yet", timeout_err, 1'b0);
    step();
    check("to_gap", cmd_valid, 1'b0);
    check("to_flag", timeout_err, 1'b1);
    step(); step();
    check("to_next", cmd, 3'd2);
    ack();
    wait_issue(10);
    check("to_grav", cmd, 3'd1);
    ack();
    check("to_sticky", timeout_err, 1'b1);

    // reset mid-operation
    restart();
    rotate = 1'b1; step(); rotate = 1'b0; right = 1'b1;
    step(); right = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    check("clr_valid", cmd_valid, 1'b0);
    check("clr_cmd", cmd, 3'd0);
    check("clr_timeout", timeout_err, 1'b0);
    @(posedge clk); #1;
    clr = 1'b0;
    count_valid(15, cnt);
    check("clr_quiet", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_scheduler.md
CMD_SCHEDULER -- requirements
Module: cmd_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000: gravity period in cycles at level 0.
REQ-002 SHALL have parameter STEP, default 3000000: period reduction per level.
REQ-003 SHALL have parameter MIN_PERIOD, default 5000000: floor on the gravity period.
REQ-004 SHALL have parameter TIMEOUT, default 1024: maximum cycles to wait for cmd_done.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-006 SHALL have port clr, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port enable, input, 1 bit: game running.
REQ-008 SHALL have ports rotate, left, right, down, input, 1 bit each: debounced single-cycle request pulses.
REQ-009 SHALL have port level, input, 4 bits: speed level 0..15.
REQ-010 SHALL have port cmd_valid, output, 1 bit: command presented to the datapath.
REQ-011 SHALL have port cmd, output, 3 bits: 0 none, 1 gravity, 2 down, 3 rotate, 4 left, 5 right.
REQ-012 SHALL have port cmd_done, input, 1 bit: datapath completion pulse.
REQ-013 SHALL have port dropped, output, 1 bit: one-cycle pulse when a request merges into an already-pending request.
REQ-014 SHALL have port timeout_err, output, 1 bit: sticky flag, cleared only by clr.

Function
REQ-015 SHALL keep a pending bit per source: gravity, down, rotate, left, right.
REQ-016 SHALL set a pending bit on its pulse while enable=1.
- If set and clear occur in the same cycle, set wins.
REQ-017 SHALL pulse dropped for one cycle when a pulse arrives while its bit is already pending; the request count is not increased.
REQ-018 SHALL compute period = max(TICK_DIV - level*STEP, MIN_PERIOD), using 32-bit unsigned arithmetic.
- A negative intermediate saturates to MIN_PERIOD.
REQ-019 SHALL run a 32-bit gravity counter while enable=1.
- When counter = period-1: set gravity pending, counter returns to 0.
- The period is re-evaluated every cycle; if counter >= period, counter restarts at 0 with no tick.
REQ-020 SHALL clear the gravity counter to 0 on cmd_done of a down (2) command (soft drop restarts gravity).
REQ-021 SHALL implement FSM IDLE, BUSY, GAP.
REQ-022 In IDLE with any pending bit: SHALL latch the highest-priority source into cmd (priority gravity > down > rotate > left > right), assert cmd_valid, and enter BUSY on the next edge.
REQ-023 In BUSY: SHALL hold cmd and cmd_valid stable until cmd_done.
- On cmd_done: clear that pending bit, deassert cmd_valid, set cmd=0, enter GAP.
REQ-024 GAP SHALL last exactly one cycle with cmd_valid=0, then go to IDLE.
- Issue-to-issue spacing is therefore at least 3 cycles.
REQ-025 In BUSY: SHALL count wait cycles; at TIMEOUT cycles without cmd_done, set timeout_err, clear that pending bit, and enter GAP.
REQ-026 SHALL ignore cmd_done outside BUSY.
REQ-027 When enable=0:
- Clear all pending bits and the gravity counter.
- Issue no new commands.
- An in-flight BUSY command still completes normally.
REQ-028 Latency: a pulse at cycle N with FSM in IDLE and no other pending bit SHALL give cmd_valid=1 at cycle N+1.

Reset
REQ-029 While clr=1, SHALL force asynchronously: state IDLE, cmd_valid=0, cmd=0, dropped=0, timeout_err=0, all pending bits 0, gravity counter 0, wait counter 0.
REQ-030 SHALL resume at the first rising edge after clr deasserts, with no spurious command.

Verification
Params: TICK_DIV=20, STEP=4, MIN_PERIOD=8, TIMEOUT=16.
REQ-031 Scenario, gravity:
- Stimulus: enable=1, level=0, datapath acks 2 cycles after cmd_valid.
- Response: cmd=1 every 20 cycles.
- With level=5: period = 8 (saturated at MIN_PERIOD).
REQ-032 Scenario, priority:
- Stimulus: rotate, left and gravity pending together in IDLE.
- Response: issue order cmd=1, 3, 4, each separated by one GAP cycle.
REQ-033 Scenario, drop:
- Stimulus: two left pulses while BUSY on rotate.
- Response: one dropped pulse; exactly one cmd=4 issued afterwards.
REQ-034 Scenario, timeout:
- Stimulus: cmd_done held 0.
- Response: timeout_err=1 after 16 BUSY cycles, FSM returns to IDLE via GAP, next pending command is issued.
REQ-035 Scenario, soft drop:
- Stimulus: down acked at gravity counter = 15.
- Response: counter returns to 0; next cmd=1 arrives 20 cycles later.
REQ-036 Scenario, reset mid-operation:
- Stimulus: clr asserted while BUSY with right pending.
- Response: cmd_valid=0 and cmd=0 immediately; no command after release until a new pulse or gravity tick.
